// File: rtl/trade_report_packetizer.sv
// Buffers 32-bit trade/dump words and frames them into byte packets: seq hi, seq lo, N, then N words MSB first.
// Latency: the first header byte is valid one cycle after a start condition (MAX_WORDS buffered, or idle flush timeout).
// Backpressure: tx_ready stalls the byte stream with data held stable; input has none, so words hitting a full FIFO are dropped and counted.
// Optional build macro TRADE_PKT_CHECKSUM_EN appends an XOR-of-all-bytes checksum byte that then carries tx_last.
module trade_report_packetizer #(
  parameter int FIFO_DEPTH    = 64,
  parameter int MAX_WORDS     = 16,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trade_valid,
  input  logic [31:0]                   trade_info,
  input  logic                          tx_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MAXW_L  = LW'(MAX_WORDS);
  localparam logic [TW-1:0] TMO_L   = TW'(FLUSH_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_PAYLOAD, S_CSUM
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_q;
  logic [TW-1:0]   timer_q;
  logic [15:0]     seq_q;
  logic [7:0]      n_q;
  logic [7:0]      word_cnt_q;
  logic [1:0]      byte_idx_q;
  logic            full, wr_en, accept, pop, start, last_word;
  logic [7:0]      n_start;
  logic [31:0]     rd_word;
`ifdef TRADE_PKT_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  // full is judged on the pre-read level, so a write while full drops even if a pop happens
  assign full      = (level_q == DEPTH_L);
  assign wr_en     = trade_valid && !full;
  assign accept    = tx_valid && tx_ready;
  assign pop       = accept && (state_q == S_PAYLOAD) && (byte_idx_q == 2'd3);
  assign last_word = (word_cnt_q == n_q - 8'd1);
  assign start     = (state_q == S_IDLE) &&
                     ((level_q >= MAXW_L) || ((level_q != '0) && (timer_q == TMO_L)));
  assign n_start   = (level_q >= MAXW_L) ? 8'(MAX_WORDS) : 8'(level_q);
  assign rd_word   = mem[rd_ptr];
  assign fifo_level = level_q;

  // word storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= trade_info;
  end

  // FIFO pointers, occupancy and drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (trade_valid && full) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // idle flush timer: runs only while idle with data waiting, saturates at the timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if ((level_q == '0) || start) begin
      timer_q <= '0;
    end else if ((state_q == S_IDLE) && (timer_q != TMO_L)) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // packet bookkeeping: latched length, byte/word position, sequence number
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seq_q      <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        n_q        <= n_start;
        word_cnt_q <= '0;
        byte_idx_q <= '0;
      end else if (accept && (state_q == S_PAYLOAD)) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) word_cnt_q <= word_cnt_q + 8'd1;
      end
      if (accept && tx_last) seq_q <= seq_q + 16'd1;
    end
  end

`ifdef TRADE_PKT_CHECKSUM_EN
  // running XOR over every accepted byte of the current packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q ^ tx_data;
    end
  end
`endif

  // next-state and byte output; outputs derive from state so reset drops tx_valid at once
  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR0;
      end
      S_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = seq_q[15:8];
        if (tx_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = seq_q[7:0];
        if (tx_ready) state_d = S_HDR2;
      end
      S_HDR2: begin
        tx_valid = 1'b1;
        tx_data  = n_q;
        if (tx_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_valid = 1'b1;
        case (byte_idx_q)
          2'd0:    tx_data = rd_word[31:24];
          2'd1:    tx_data = rd_word[23:16];
          2'd2:    tx_data = rd_word[15:8];
          default: tx_data = rd_word[7:0];
        endcase
`ifdef TRADE_PKT_CHECKSUM_EN
        if (tx_ready && (byte_idx_q == 2'd3) && last_word) state_d = S_CSUM;
`else
        tx_last = (byte_idx_q == 2'd3) && last_word;
        if (tx_ready && tx_last) state_d = S_IDLE;
`endif
      end
`ifdef TRADE_PKT_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        tx_last  = 1'b1;
        if (tx_ready) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trade_report_packetizer.sv
// Scoreboard bench for trade_report_packetizer: a word-queue model chunks each burst into
// packets of at most MAX_WORDS and queues the expected bytes; a negedge monitor pops and compares.
module tb_trade_report_packetizer;
  localparam int FIFO_DEPTH    = 64;
  localparam int MAX_WORDS     = 16;
  localparam int FLUSH_TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        trade_valid;
  logic [31:0] trade_info;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0] drop_count;
  logic        overflow;

  trade_report_packetizer #(
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_WORDS(MAX_WORDS), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .trade_valid(trade_valid), .trade_info(trade_info),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .fifo_level(fifo_level), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  exp_q[$];     // {last, data}
  logic [31:0] pend_q[$];    // words the model expects to be packetized
  logic [31:0] drv_q[$];     // words to drive
  logic [15:0] seq_m;
  int          bytes_seen = 0;
  bit          rdy_rand = 1'b0;
  logic        rdy_fixed = 1'b1;
  bit          held = 1'b0;
  logic [8:0]  held_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // sink readiness: fixed level or a coin flip every cycle
  always @(posedge clk) begin
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // monitor: a byte shown with tx_ready high is accepted at the next rising edge
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      if (held) check("stall_stable", {23'd0, tx_last, tx_data}, {23'd0, held_byte});
      if (tx_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {23'd0, tx_last, tx_data}, 32'h1FF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, e});
          bytes_seen++;
        end
      end else begin
        held = 1'b1;
        held_byte = {tx_last, tx_data};
      end
    end else begin
      held = 1'b0;
    end
  end

  // reference model: split pending words into packets of at most MAX_WORDS
  task automatic model_packets();
    while (pend_q.size() > 0) begin
      int         n;
      logic [7:0] cs;
      logic [7:0] b;
      logic [7:0] hdr[3];
      n  = (pend_q.size() > MAX_WORDS) ? MAX_WORDS : pend_q.size();
      cs = 8'h00;
      hdr[0] = seq_m[15:8];
      hdr[1] = seq_m[7:0];
      hdr[2] = 8'(n);
      for (int h = 0; h < 3; h++) begin
        exp_q.push_back({1'b0, hdr[h]});
        cs ^= hdr[h];
      end
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        bit          lst;
        w = pend_q.pop_front();
        for (int j = 0; j < 4; j++) begin
          b   = 8'(w >> (24 - 8 * j));
          lst = (i == n - 1) && (j == 3);
`ifdef TRADE_PKT_CHECKSUM_EN
          lst = 1'b0;
`endif
          exp_q.push_back({lst, b});
          cs ^= b;
        end
      end
`ifdef TRADE_PKT_CHECKSUM_EN
      exp_q.push_back({1'b1, cs});
`endif
      seq_m = seq_m + 16'd1;
    end
  endtask

  task automatic drive_words();
    while (drv_q.size() > 0) begin
      @(posedge clk); #1;
      trade_valid = 1'b1;
      trade_info  = drv_q.pop_front();
    end
    @(posedge clk); #1;
    trade_valid = 1'b0;
  endtask

  // queue k words (counting from base, or random), model them, then drive them back-to-back
  task automatic burst(input int k, input bit rnd, input logic [31:0] base, input int keep);
    for (int i = 0; i < k; i++) begin
      logic [31:0] w;
      w = rnd ? $urandom : base + 32'(i);
      drv_q.push_back(w);
      if (i < keep) pend_q.push_back(w);
    end
    model_packets();
    drive_words();
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || tx_valid || fifo_level != 0) && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(cyc < 6000), 32'd1);
  endtask

  initial begin
    int  b0;
    bit  early;
    rst = 1'b1; trade_valid = 1'b0; trade_info = '0; seq_m = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;

    // full batch of 16 triggers immediately: 67 bytes, seq 0
    b0 = bytes_seen;
    burst(16, 1'b0, 32'h1, 16);
    wait_done("drain_16");
    check("len_16", 32'(bytes_seen - b0), 32'(`ifdef TRADE_PKT_CHECKSUM_EN 68 `else 67 `endif));
    check("level_after_16", 32'(fifo_level), 32'd0);

    // lone word waits out the flush timeout, seq 1
    drv_q.push_back(32'hDEADBEEF); pend_q.push_back(32'hDEADBEEF);
    model_packets();
    drive_words();
    early = 1'b0;
    for (int i = 0; i < FLUSH_TIMEOUT - 10; i++) begin
      @(negedge clk);
      if (tx_valid) early = 1'b1;
    end
    check("no_early_flush", 32'(early), 32'd0);
    wait_done("drain_timeout_pkt");

    // stalled sink with 70 words: FIFO fills to 64, 6 drops, then four full packets
    rdy_fixed = 1'b0;
    burst(70, 1'b0, 32'h100, FIFO_DEPTH);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("ovf_drops", 32'(drop_count), 32'd6);
    check("ovf_sticky", 32'(overflow), 32'd1);
    rdy_fixed = 1'b1;
    wait_done("drain_ovf");
    check("drops_hold", 32'(drop_count), 32'd6);

    // random sink readiness: a 5-word timeout packet, then random bursts up to 40 words
    rdy_rand = 1'b1;
    burst(5, 1'b1, 32'h0, 5);
    wait_done("drain_rand5");
    for (int t = 0; t < 5; t++) begin
      int k;
      k = $urandom_range(1, 40);
      burst(k, 1'b1, 32'h0, k);
      wait_done("drain_rand");
    end
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;

    // reset in the middle of a payload
    b0 = bytes_seen;
    burst(16, 1'b1, 32'h0, 16);
    for (int c = 0; c < 200 && bytes_seen < b0 + 10; c++) @(posedge clk);
    check("reached_payload", 32'(bytes_seen >= b0 + 10), 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_drops", 32'(drop_count), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    seq_m = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // first packet after reset restarts at seq 0
    burst(3, 1'b1, 32'h0, 3);
    wait_done("drain_after_rst");
`ifdef TRADE_PKT_CHECKSUM_EN
    burst(1, 1'b0, 32'h01020304, 1);
    wait_done("drain_csum");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
